eeprom_burst_seq: RTL and testbench
===================================

Name: eeprom_burst_seq

Overview:
- Command sequencer between the debounced key pulses and the I2C controller (i2c_ctrler).
- A write request stores BURST_LEN bytes of a fixed pattern at consecutive EEPROM addresses, inserting the AT24C02 write-cycle delay (tWR) after each byte.
- A verify request reads the same addresses back and compares each byte with the pattern.
- Reports busy, pass/fail, mismatch count and the last byte read, for display on LEDs.

Parameters:
- SYS_CLK_FREQ, 50000000, system clock frequency in Hz.
- TWR_US, 5000, EEPROM write-cycle wait after each write_done, in microseconds.
- BURST_LEN, 4, number of bytes per burst (1..16).
- BASE_ADDR, 8'd32, first register address.
- DEV_ADDR, 7'b1010000, 7-bit device address.
- SEED, 8'h0A, pattern seed; byte i = SEED + i (mod 256).
- DONE_TIMEOUT, 1000000, maximum cycles to wait for a done pulse.

Ports:
- sclk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- wr_req  input  1  single-cycle pulse that starts a write burst.
- rd_req  input  1  single-cycle pulse that starts a verify burst.
- equi_addr  output  7  device address to the controller; always DEV_ADDR.
- reg_addr  output  8  register address for the current transfer.
- write_byte  output  8  data for the current write.
- write_trigger  output  1  single-cycle pulse that starts one controller write.
- read_trigger  output  1  single-cycle pulse that starts one controller read.
- write_done  input  1  single-cycle pulse from the controller when a write completes.
- read_done  input  1  single-cycle pulse from the controller when a read completes; read_byte is valid in the same cycle.
- read_byte  input  8  data returned by the controller.
- busy  output  1  high whenever the FSM is not in IDLE.
- pass  output  1  high when the last verify completed with zero mismatches.
- fail  output  1  high when the last verify had a mismatch, or when any burst timed out.
- timeout  output  1  high when the last burst was aborted on timeout.
- err_cnt  output  4  number of mismatches in the last verify; saturates at 15.
- last_byte  output  8  most recent read_byte captured.

Behaviour:
- Reset values: reg_addr = BASE_ADDR; write_byte = SEED; every other output = 0, except equi_addr, which is the constant DEV_ADDR. Reset asserted mid-burst aborts the burst immediately; no trigger is issued after reset releases until a new request arrives.
- Index counter idx runs from 0 to BURST_LEN-1.
  - reg_addr = BASE_ADDR + idx, using 8-bit wrap (255 is followed by 0).
  - write_byte = SEED + idx, using 8-bit wrap.
  - Both are registered and held stable from the trigger cycle until the matching done pulse.
- FSM states: IDLE, W_ISSUE, W_WAIT, W_TWR, R_ISSUE, R_WAIT, FINISH.
- IDLE:
  - wr_req goes to W_ISSUE. rd_req goes to R_ISSUE and clears pass, fail, timeout and err_cnt.
  - wr_req also clears timeout and fail. pass and err_cnt keep their last verify result.
  - In both cases idx is cleared.
  - If wr_req and rd_req arrive in the same cycle, the write wins and the read request is dropped.
  - Requests that arrive while busy are ignored, not queued.
- W_ISSUE: write_trigger is high for exactly this cycle. Next state is W_WAIT; the timeout counter is cleared.
- W_WAIT:
  - On write_done, go to W_TWR and load the delay counter with SYS_CLK_FREQ/1000000*TWR_US - 1.
  - If DONE_TIMEOUT cycles pass without write_done, set timeout and fail, then go to FINISH.
- W_TWR:
  - Count the delay down to 0.
  - At 0: if idx == BURST_LEN-1, go to FINISH; otherwise increment idx and go to W_ISSUE.
  - For BURST_LEN=4, the first write_trigger of the next byte follows the delay expiry by 1 cycle.
- R_ISSUE: read_trigger is high for exactly this cycle. Next state is R_WAIT; the timeout counter is cleared.
- R_WAIT:
  - On read_done, capture last_byte = read_byte.
  - If read_byte != SEED + idx, increment err_cnt, saturating at 15.
  - Then: if idx == BURST_LEN-1, go to FINISH; otherwise increment idx and go to R_ISSUE. There is no tWR wait between reads.
  - If DONE_TIMEOUT cycles pass without read_done, set timeout and fail, then go to FINISH.
- FINISH (1 cycle):
  - After a completed verify, set pass = (err_cnt == 0) and fail = (err_cnt != 0), using err_cnt including any mismatch found in the final R_WAIT cycle.
  - Then go to IDLE. busy drops on entry to IDLE.
- Done pulses received in any state other than the matching wait state are ignored.
- write_trigger and read_trigger are never high in the same cycle, and never for more than one cycle per transfer.

Test Plan:
- Write burst (BURST_LEN=4, TWR_US reduced to 1): wr_req pulse → four write_trigger pulses with reg_addr/write_byte = 32/0x0A, 33/0x0B, 34/0x0C, 35/0x0D. Each next trigger comes 50 cycles plus 1 after write_done. busy falls 2 cycles after the delay following the 4th write.
- Verify, all match: rd_req, with a model returning 0x0A..0x0D → pass=1, fail=0, err_cnt=0, last_byte=0x0D.
- Verify, mismatch: the model returns 0xFF at address 33 → err_cnt=1, fail=1, pass=0, last_byte=0x0D.
- Timeout (DONE_TIMEOUT=100): write_done is never pulsed → after 100 cycles in W_WAIT, timeout=1, fail=1, busy=0, and no further write_trigger.
- Simultaneous wr_req and rd_req in IDLE → a write burst only; no read_trigger. An rd_req issued mid-burst is ignored.
- Wrap-around and reset: BASE_ADDR=254 gives reg_addr 254, 255, 0, 1. Asserting rst in W_TWR clears all outputs at once; after release, no trigger occurs without a new request.

Source files
------------

// File: rtl/eeprom_burst_seq.sv
// eeprom_burst_seq: sequences write and verify bursts of a seeded byte pattern
// through an I2C controller and reports the result for the LEDs.
module eeprom_burst_seq #(
    parameter int         SYS_CLK_FREQ = 50000000,
    parameter int         TWR_US       = 5000,
    parameter int         BURST_LEN    = 4,
    parameter logic [7:0] BASE_ADDR    = 8'd32,
    parameter logic [6:0] DEV_ADDR     = 7'b1010000,
    parameter logic [7:0] SEED         = 8'h0A,
    parameter int         DONE_TIMEOUT = 1000000
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [6:0] equi_addr,
    output logic [7:0] reg_addr,
    output logic [7:0] write_byte,
    output logic       write_trigger,
    output logic       read_trigger,
    input  logic       write_done,
    input  logic       read_done,
    input  logic [7:0] read_byte,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic       timeout,
    output logic [3:0] err_cnt,
    output logic [7:0] last_byte
);
    localparam logic [31:0] TWR_LOAD = 32'(SYS_CLK_FREQ / 1000000 * TWR_US - 1);
    localparam logic [31:0] TO_LAST  = 32'(DONE_TIMEOUT - 1);
    localparam logic [3:0]  IDX_LAST = 4'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, W_ISSUE, W_WAIT, W_TWR, R_ISSUE, R_WAIT, FINISH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] dly_q, dly_d;
    logic [31:0] to_q, to_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  write_byte_q, write_byte_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  last_byte_q, last_byte_d;
    logic        vfy_q, vfy_d;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dly_q        <= '0;
            to_q         <= '0;
            reg_addr_q   <= BASE_ADDR;
            write_byte_q <= SEED;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
            last_byte_q  <= '0;
            vfy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dly_q        <= dly_d;
            to_q         <= to_d;
            reg_addr_q   <= reg_addr_d;
            write_byte_q <= write_byte_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
            last_byte_q  <= last_byte_d;
            vfy_q        <= vfy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dly_d         = dly_q;
        to_d          = to_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        err_cnt_d     = err_cnt_q;
        last_byte_d   = last_byte_q;
        vfy_d         = vfy_q;
        write_trigger = 1'b0;
        read_trigger  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d   = W_ISSUE;
                    idx_d     = '0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end else if (rd_req) begin
                    state_d   = R_ISSUE;
                    idx_d     = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_cnt_d = '0;
                end
            end
            W_ISSUE: begin
                write_trigger = 1'b1;
                to_d          = '0;
                state_d       = W_WAIT;
            end
            W_WAIT: begin
                if (write_done) begin
                    dly_d   = TWR_LOAD;
                    state_d = W_TWR;
                end else if (to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = FINISH;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            W_TWR: begin
                if (dly_q != '0) begin
                    dly_d = dly_q - 32'd1;
                end else if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = W_ISSUE;
                end
            end
            R_ISSUE: begin
                read_trigger = 1'b1;
                to_d         = '0;
                state_d      = R_WAIT;
            end
            R_WAIT: begin
                if (read_done) begin
                    last_byte_d = read_byte;
                    err_cnt_d   = (read_byte != SEED + 8'(idx_q) && err_cnt_q != 4'd15) ? err_cnt_q + 4'd1 : err_cnt_q;
                    vfy_d       = idx_q == IDX_LAST;
                    idx_d       = idx_q == IDX_LAST ? idx_q : idx_q + 4'd1;
                    state_d     = idx_q == IDX_LAST ? FINISH : R_ISSUE;
                end else if (to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = FINISH;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            FINISH: begin
                // err_cnt_q already includes a mismatch seen in the final read
                pass_d  = vfy_q ? err_cnt_q == '0 : pass_q;
                fail_d  = vfy_q ? err_cnt_q != '0 : fail_q;
                vfy_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        reg_addr_d   = BASE_ADDR + 8'(idx_d);
        write_byte_d = SEED + 8'(idx_d);
    end

    assign equi_addr  = DEV_ADDR;
    assign reg_addr   = reg_addr_q;
    assign write_byte = write_byte_q;
    assign busy       = state_q != IDLE;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign err_cnt    = err_cnt_q;
    assign last_byte  = last_byte_q;
endmodule

// File: tb/tb_eeprom_burst_seq.sv
// tb_eeprom_burst_seq: directed bursts against two sequencers (base 32 and base 254)
// driven by an EEPROM/controller responder, checked against a spec-level model.
module tb_eeprom_burst_seq;
    localparam logic [7:0] SEED = 8'h0A;
    localparam int LAT = 3;

    logic sclk = 1'b0, rst = 1'b1, wr_req = 1'b0, rd_req = 1'b0;
    logic write_done = 1'b0, read_done = 1'b0;
    logic [7:0] read_byte = '0;
    logic [6:0] ea[2];
    logic [7:0] ra[2], wb[2], lb[2];
    logic       wt[2], rt[2], bz[2], ps[2], fl[2], tm[2];
    logic [3:0] ec[2];

    eeprom_burst_seq #(.TWR_US(1), .DONE_TIMEOUT(100), .BASE_ADDR(8'd32)) dut0 (
        .sclk(sclk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .equi_addr(ea[0]),
        .reg_addr(ra[0]), .write_byte(wb[0]), .write_trigger(wt[0]), .read_trigger(rt[0]),
        .write_done(write_done), .read_done(read_done), .read_byte(read_byte), .busy(bz[0]),
        .pass(ps[0]), .fail(fl[0]), .timeout(tm[0]), .err_cnt(ec[0]), .last_byte(lb[0]));
    eeprom_burst_seq #(.TWR_US(1), .DONE_TIMEOUT(100), .BASE_ADDR(8'd254)) dut1 (
        .sclk(sclk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .equi_addr(ea[1]),
        .reg_addr(ra[1]), .write_byte(wb[1]), .write_trigger(wt[1]), .read_trigger(rt[1]),
        .write_done(write_done), .read_done(read_done), .read_byte(read_byte), .busy(bz[1]),
        .pass(ps[1]), .fail(fl[1]), .timeout(tm[1]), .err_cnt(ec[1]), .last_byte(lb[1]));

    always #5 sclk = ~sclk;

    int errors = 0, checks = 0;
    int cyc = 0, done_cyc = 0, trig_cyc = 0;
    int n[2], fall_cyc[2];
    logic [7:0] base[2] = '{8'd32, 8'd254};
    logic pt[2] = '{1'b0, 1'b0};
    logic pb[2] = '{1'b0, 1'b0};
    logic active = 1'b0, kind = 1'b0, respond = 1'b1, corrupt = 1'b0;
    logic [7:0] mem[256];
    logic [7:0] exp_mem[4];
    logic m_pass = 0, m_fail = 0, m_to = 0;
    logic [3:0] m_err = 0;
    logic [7:0] m_last = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Controller + EEPROM: answers each trigger LAT cycles later
    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(posedge sclk); #1;
            write_done = 1'b0;
            read_done  = 1'b0;
            if (wt[0] && respond) begin
                a = ra[0];
                mem[a] = wb[0];
                repeat (LAT) begin @(posedge sclk); #1; end
                write_done = 1'b1;
            end else if (rt[0] && respond) begin
                a = ra[0];
                repeat (LAT) begin @(posedge sclk); #1; end
                read_byte = (corrupt && a == 8'd33) ? 8'hFF : mem[a];
                read_done = 1'b1;
            end
        end
    end

    always @(negedge sclk) begin
        logic [7:0] e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (wt[d] || rt[d]) begin
                e = base[d] + 8'(n[d]);
                chk("trig_exclusive", 32'(wt[d] & rt[d]), 0);
                chk("trig_when_active", 32'(active), 1);
                chk("trig_kind", 32'(rt[d]), 32'(kind));
                chk("trig_reg_addr", 32'(ra[d]), 32'(e));
                if (!kind) chk("trig_write_byte", 32'(wb[d]), 32'(SEED + 8'(n[d])));
                chk("trig_count", 32'(n[d] < 4), 1);
                chk("trig_single_cycle", 32'(pt[d]), 0);
                chk("trig_busy", 32'(bz[d]), 1);
                chk("equi_addr", 32'(ea[d]), 32'h50);
                if (d == 0 && n[0] > 0) chk("trig_gap", 32'(cyc - done_cyc), kind ? 1 : 51);
                if (d == 0) trig_cyc = cyc;
                n[d]++;
            end
            if (write_done || read_done) begin
                chk("hold_reg_addr", 32'(ra[d]), 32'(8'(base[d] + 8'(n[d] - 1))));
                if (write_done) chk("hold_write_byte", 32'(wb[d]), 32'(SEED + 8'(n[d] - 1)));
            end
            if (pb[d] && !bz[d]) fall_cyc[d] = cyc;
            pt[d] = wt[d] | rt[d];
            pb[d] = bz[d];
        end
        if (write_done || read_done) done_cyc = cyc;
    end

    task automatic pulse(input logic w, input logic r);
        @(posedge sclk); #1;
        wr_req = w;
        rd_req = r;
        @(posedge sclk); #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge sclk);
            if (!bz[0]) break;
        end
        if (k == 3000) chk("idle_wait_expired", 0, 1);
        @(posedge sclk); #1;
    endtask

    task automatic check_status(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_pass"}, 32'(ps[d]), 32'(m_pass));
            chk({tag, "_fail"}, 32'(fl[d]), 32'(m_fail));
            chk({tag, "_timeout"}, 32'(tm[d]), 32'(m_to));
            chk({tag, "_err_cnt"}, 32'(ec[d]), 32'(m_err));
            chk({tag, "_last_byte"}, 32'(lb[d]), 32'(m_last));
            chk({tag, "_busy"}, 32'(bz[d]), 0);
        end
    endtask

    // fall_ref: 0 = last done pulse, 1 = last trigger
    task automatic burst(input logic w, input logic r, input bit rd_mid, input int exp_n,
                         input bit fall_ref, input int exp_fall);
        active = 1'b1;
        kind   = !w;
        n      = '{0, 0};
        pulse(w, r);
        if (rd_mid) begin
            repeat (100) @(posedge sclk);
            pulse(1'b0, 1'b1);
        end
        wait_idle();
        active = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("burst_transfers", 32'(n[d]), 32'(exp_n));
            chk("busy_fall_time", 32'(fall_cyc[d] - (fall_ref ? trig_cyc : done_cyc)), 32'(exp_fall));
        end
    endtask

    task automatic model_verify();
        logic [7:0] b;
        int e = 0;
        for (int i = 0; i < 4; i++) begin
            b = (corrupt && i == 1) ? 8'hFF : exp_mem[i];
            if (b != SEED + 8'(i)) e++;
            m_last = b;
        end
        m_err  = e > 15 ? 4'd15 : 4'(e);
        m_pass = e == 0;
        m_fail = e != 0;
        m_to   = 1'b0;
    endtask

    initial begin
        n = '{0, 0};
        fall_cyc = '{0, 0};
        repeat (3) @(posedge sclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_reg_addr", 32'(ra[d]), 32'(base[d]));
            chk("rst_write_byte", 32'(wb[d]), 32'h0A);
            chk("rst_equi_addr", 32'(ea[d]), 32'h50);
            chk("rst_triggers", 32'({wt[d], rt[d]}), 0);
        end
        check_status("rst");
        rst = 1'b0;
        repeat (3) @(posedge sclk);

        // Write burst with an ignored mid-burst rd_req
        burst(1'b1, 1'b0, 1'b1, 4, 1'b0, 52);
        for (int i = 0; i < 4; i++) exp_mem[i] = SEED + 8'(i);
        m_fail = 1'b0;
        m_to   = 1'b0;
        check_status("write");
        chk("pin_mem35", 32'(mem[35]), 32'h0D);
        chk("pin_mem32", 32'(mem[32]), 32'h0A);

        // Verify, all match
        burst(1'b0, 1'b1, 1'b0, 4, 1'b0, 2);
        model_verify();
        check_status("verify_ok");
        chk("pin_pass", 32'(ps[0]), 1);
        chk("pin_last_byte", 32'(lb[0]), 32'h0D);

        // Verify with 0xFF returned at address 33
        corrupt = 1'b1;
        burst(1'b0, 1'b1, 1'b0, 4, 1'b0, 2);
        model_verify();
        corrupt = 1'b0;
        check_status("verify_bad");
        chk("pin_err_cnt", 32'(ec[0]), 1);
        chk("pin_fail", 32'(fl[0]), 1);

        // Simultaneous requests: write wins, verify result retained
        burst(1'b1, 1'b1, 1'b0, 4, 1'b0, 52);
        m_fail = 1'b0;
        m_to   = 1'b0;
        check_status("simul");

        // Timeout: no write_done ever
        respond = 1'b0;
        burst(1'b1, 1'b0, 1'b0, 1, 1'b1, 102);
        m_fail = 1'b1;
        m_to   = 1'b1;
        check_status("timeout");
        chk("pin_timeout", 32'(tm[0]), 1);
        repeat (300) @(posedge sclk);
        chk("timeout_no_retrigger", 32'(n[0]), 1);
        respond = 1'b1;

        // Reset asserted during the tWR wait
        active = 1'b1;
        kind   = 1'b0;
        n      = '{0, 0};
        pulse(1'b1, 1'b0);
        repeat (15) @(posedge sclk);
        #1;
        chk("pre_rst_busy", 32'(bz[0]), 1);
        rst = 1'b1;
        #1;
        active = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_reg_addr", 32'(ra[d]), 32'(base[d]));
            chk("midrst_write_byte", 32'(wb[d]), 32'h0A);
            chk("midrst_triggers", 32'({wt[d], rt[d]}), 0);
        end
        {m_pass, m_fail, m_to, m_err, m_last} = '0;
        check_status("midrst");
        repeat (3) @(posedge sclk);
        #1;
        rst = 1'b0;
        repeat (200) @(posedge sclk);
        chk("no_trig_after_rst", 32'(n[0]), 1);
        chk("idle_after_rst", 32'(bz[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
